// File: rtl/neat_sched_pkg.sv
// Shared types and defaults for the NEAT index-counter scheduler.
// Imported by the arbiter and by count_sched.
package neat_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_CNT_W   = 8;

  // Pointer width for a requester index; never below 1 bit so the ports stay legal.
  function automatic int ptr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after rr_ptr wins, cyclically.
// The pointer register itself lives in count_sched.
module rr_arbiter
  import neat_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int PW = ptr_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [PW-1:0]      winner_idx,
  output logic               any_req
);

  logic [PW:0] cand;
  logic        found;

  // Walk the requesters starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(NUM_REQ)) begin
        cand = cand - (PW+1)'(NUM_REQ);
      end
      if (!found && req[cand[PW-1:0]]) begin
        found      = 1'b1;
        winner_idx = cand[PW-1:0];
      end
    end
    if (found) begin
      winner[winner_idx] = 1'b1;
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/count_sched.sv
// Shares one index counter among NUM_REQ requesters: round-robin grant,
// then a valid/ready scan 0..len-1 with a one-cycle done pulse to the owner.
module count_sched
  import neat_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] len,
  output logic [NUM_REQ-1:0]       grant,
  output logic [CNT_W-1:0]         idx,
  output logic                     idx_valid,
  input  logic                     idx_ready,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy
);

  localparam int PW = ptr_w(NUM_REQ);

  state_t             state;
  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      owner;
  logic [CNT_W-1:0]   len_lat;
  logic [NUM_REQ-1:0] win_oh;
  logic [PW-1:0]      win_idx;
  logic               any_req;
  logic [CNT_W-1:0]   sel_len;
  logic [CNT_W-1:0]   last_idx;
  logic [PW-1:0]      next_ptr;
  logic               transfer;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req),
    .rr_ptr    (rr_ptr),
    .winner    (win_oh),
    .winner_idx(win_idx),
    .any_req   (any_req)
  );

  assign sel_len  = len[int'(win_idx)*CNT_W +: CNT_W];
  // Only meaningful in RUN, where len_lat is known to be non-zero.
  assign last_idx = len_lat - CNT_W'(1);
  assign next_ptr = (owner == PW'(NUM_REQ-1)) ? '0 : owner + PW'(1);
  assign transfer = idx_valid && idx_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      len_lat   <= '0;
      grant     <= '0;
      idx       <= '0;
      idx_valid <= 1'b0;
      done      <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant   <= win_oh;
            owner   <= win_idx;
            len_lat <= sel_len;
            idx     <= '0;
            busy    <= 1'b1;
            if (sel_len != '0) begin
              state     <= RUN;
              idx_valid <= 1'b1;
            end else begin
              // Empty scan: skip straight to the completion pulse.
              state <= DONE;
              done  <= win_oh;
            end
          end
        end
        RUN: begin
          if (transfer) begin
            if (idx == last_idx) begin
              state     <= DONE;
              idx_valid <= 1'b0;
              done      <= grant;
            end else begin
              idx <= idx + CNT_W'(1);
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          grant  <= '0;
          done   <= '0;
          busy   <= 1'b0;
          idx    <= '0;
          rr_ptr <= next_ptr;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_sched.sv
// Bench for count_sched: directed scans checked against a transaction-level
// model every cycle, plus literal expectations for each scenario.
`timescale 1ns/1ps
module tb_count_sched;

  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 8;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CNT_W-1:0] len;
  logic [NUM_REQ-1:0]       grant;
  logic [CNT_W-1:0]         idx;
  logic                     idx_valid;
  logic                     idx_ready;
  logic [NUM_REQ-1:0]       done;
  logic                     busy;

  int checks   = 0;
  int failures = 0;

  int m_owner, m_idx, m_len, m_sent, m_ptr;
  bit m_fin;
  int exp_grant, exp_idx, exp_valid, exp_done, exp_busy;

  int acc_q[$];
  int done_q[$];
  int grant_q[$];
  int seen_q[$];
  int exp_q[$];
  int last_grant = 0;

  count_sched #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .len      (len),
    .grant    (grant),
    .idx      (idx),
    .idx_valid(idx_valid),
    .idx_ready(idx_ready),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic check_seq(input string name, input int act[$], input int expv[$]);
    check_output({name, "_len"}, act.size(), expv.size());
    for (int i = 0; i < expv.size() && i < act.size(); i++) begin
      check_output($sformatf("%s[%0d]", name, i), act[i], expv[i]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [NUM_REQ-1:0] r,
                                input logic [NUM_REQ*CNT_W-1:0] l,
                                input logic rdy);
    req       = r;
    len       = l;
    idx_ready = rdy;
  endtask

  task automatic clear_logs();
    acc_q.delete();
    done_q.delete();
    grant_q.delete();
    seen_q.delete();
  endtask

  task automatic wait_done(input int bound);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < bound && !seen; n++) begin
      tick();
      if (done != '0) seen = 1'b1;
    end
    check_output("wait_done", int'(seen), 1);
  endtask

  function automatic int pick_winner(input logic [NUM_REQ-1:0] r, input int p);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic int len_of(input int w);
    return int'(len[w*CNT_W +: CNT_W]);
  endfunction

  // Model: who owns the counter, how many indices were handed out, and
  // whether the scan is in its completion cycle.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_owner <= -1;
      m_idx   <= 0;
      m_len   <= 0;
      m_sent  <= 0;
      m_ptr   <= 0;
      m_fin   <= 1'b0;
    end else if (m_owner < 0) begin
      if (req != '0) begin
        m_owner <= pick_winner(req, m_ptr);
        m_len   <= len_of(pick_winner(req, m_ptr));
        m_idx   <= 0;
        m_sent  <= 0;
        m_fin   <= (len_of(pick_winner(req, m_ptr)) == 0);
      end
    end else if (m_fin) begin
      m_ptr   <= (m_owner + 1) % NUM_REQ;
      m_owner <= -1;
      m_idx   <= 0;
      m_fin   <= 1'b0;
    end else if (idx_ready) begin
      m_sent <= m_sent + 1;
      if (m_sent + 1 == m_len) m_fin <= 1'b1;
      else m_idx <= m_idx + 1;
    end
  end

  // Every-cycle comparison plus logging of accepted indices, grants and done pulses.
  always @(negedge clk) begin
    exp_grant = (m_owner >= 0) ? (1 << m_owner) : 0;
    exp_busy  = (m_owner >= 0) ? 1 : 0;
    exp_valid = (m_owner >= 0 && !m_fin) ? 1 : 0;
    exp_done  = m_fin ? exp_grant : 0;
    exp_idx   = m_idx;
    check_output("grant", int'(grant), exp_grant);
    check_output("idx", int'(idx), exp_idx);
    check_output("idx_valid", int'(idx_valid), exp_valid);
    check_output("done", int'(done), exp_done);
    check_output("busy", int'(busy), exp_busy);
    if (idx_valid && idx_ready) acc_q.push_back(int'(idx));
    if (done != '0) done_q.push_back(int'(done));
    if (grant != '0 && int'(grant) != last_grant) grant_q.push_back(int'(grant));
    last_grant = int'(grant);
  end

  initial begin
    int bad;
    logic [4:0] pat;
    rst = 1'b0;
    apply_stimulus('0, '0, 1'b0);

    $display("[TB] reset state");
    repeat (3) tick();
    check_output("rst_grant", int'(grant), 0);
    check_output("rst_busy", int'(busy), 0);
    check_output("rst_valid", int'(idx_valid), 0);
    check_output("rst_idx", int'(idx), 0);
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] single requester, len 5");
    clear_logs();
    apply_stimulus(4'b0001, {8'd0, 8'd0, 8'd0, 8'd5}, 1'b1);
    tick();
    check_output("single_grant", int'(grant), 1);
    check_output("single_first_valid", int'(idx_valid), 1);
    req = '0;
    wait_done(20);
    tick();
    check_output("single_grant_after", int'(grant), 0);
    exp_q = {0, 1, 2, 3, 4};
    check_seq("single_idx", acc_q, exp_q);
    exp_q = {1};
    check_seq("single_done", done_q, exp_q);

    $display("[TB] backpressure, len 3");
    clear_logs();
    apply_stimulus(4'b0001, {8'd0, 8'd0, 8'd0, 8'd3}, 1'b1);
    tick();
    req = '0;
    pat = 5'b11001;
    for (int i = 0; i < 5; i++) begin
      idx_ready = pat[i];
      seen_q.push_back(int'(idx));
      tick();
    end
    check_output("bp_done", int'(done), 1);
    check_output("bp_valid_end", int'(idx_valid), 0);
    exp_q = {0, 1, 1, 1, 2};
    check_seq("bp_idx_seen", seen_q, exp_q);
    tick();
    check_output("bp_done_clear", int'(done), 0);
    exp_q = {0, 1, 2};
    check_seq("bp_accepted", acc_q, exp_q);

    $display("[TB] round-robin, all len 2");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    clear_logs();
    apply_stimulus(4'b1111, {4{8'd2}}, 1'b1);
    for (int n = 0; n < 60 && grant_q.size() < 5; n++) tick();
    req = '0;
    for (int n = 0; n < 20 && (busy || done != '0); n++) tick();
    tick();
    exp_q = {1, 2, 4, 8, 1};
    check_seq("rr_grants", grant_q, exp_q);
    check_seq("rr_dones", done_q, exp_q);
    check_output("rr_indices", acc_q.size(), 10);

    $display("[TB] zero length");
    clear_logs();
    apply_stimulus(4'b0100, '0, 1'b1);
    tick();
    check_output("zero_grant", int'(grant), 4);
    check_output("zero_done", int'(done), 4);
    check_output("zero_valid", int'(idx_valid), 0);
    req = '0;
    tick();
    check_output("zero_grant_after", int'(grant), 0);
    check_output("zero_busy_after", int'(busy), 0);
    check_output("zero_indices", acc_q.size(), 0);

    $display("[TB] async reset mid-scan");
    apply_stimulus(4'b0001, {8'd0, 8'd0, 8'd0, 8'd8}, 1'b1);
    tick();
    req = '0;
    repeat (3) tick();
    check_output("ar_idx_before", int'(idx), 3);
    #2;
    rst = 1'b0;
    #1;
    check_output("ar_grant", int'(grant), 0);
    check_output("ar_idx", int'(idx), 0);
    check_output("ar_valid", int'(idx_valid), 0);
    check_output("ar_busy", int'(busy), 0);
    check_output("ar_done", int'(done), 0);
    apply_stimulus(4'b0010, {8'd0, 8'd0, 8'd3, 8'd0}, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    clear_logs();
    tick();
    check_output("ar_regrant", int'(grant), 2);
    req = '0;
    wait_done(20);
    tick();
    exp_q = {2};
    check_seq("ar_done_q", done_q, exp_q);
    exp_q = {0, 1, 2};
    check_seq("ar_idx_q", acc_q, exp_q);

    $display("[TB] max length 255");
    clear_logs();
    apply_stimulus(4'b0001, {8'd0, 8'd0, 8'd0, 8'd255}, 1'b1);
    tick();
    req = '0;
    wait_done(300);
    tick();
    check_output("max_count", acc_q.size(), 255);
    bad = 0;
    for (int i = 0; i < acc_q.size(); i++) begin
      if (acc_q[i] != i) bad++;
    end
    check_output("max_seq_errors", bad, 0);
    if (acc_q.size() > 0) check_output("max_last", acc_q[acc_q.size()-1], 254);
    check_output("max_done_count", done_q.size(), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/count_sched.md
Name: count_sched

Overview:
- Scheduler sharing one 8-bit index counter (the gene/node scan counter) among NUM_REQ requesters in the NEAT datapath.
- Each requester asks for a scan of length len. count_sched arbitrates round-robin, then sequences the counter from 0 to len-1 under a valid/ready handshake.
- It pulses done back to the winning requester when the scan completes.
- Sits between the genome-evaluation engines and the shared index counter / gene-memory read port.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CNT_W, 8, counter and length width in bits

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
req  in  NUM_REQ  per-requester scan request, level
len  in  NUM_REQ*CNT_W  per-requester scan length; requester i uses bits [i*CNT_W +: CNT_W]
grant  out  NUM_REQ  one-hot owner of the counter, all-zero when idle
idx  out  CNT_W  current scan index
idx_valid  out  1  idx is valid for the consumer
idx_ready  in  1  consumer accepts idx this cycle
done  out  NUM_REQ  one-cycle pulse to the finished requester
busy  out  1  high whenever the FSM is not IDLE

Behaviour:
- Reset, while rst=0, asynchronous:
  - Outputs: grant=0, idx=0, idx_valid=0, done=0, busy=0.
  - Internal state: state=IDLE, rr_ptr=0, so requester 0 has highest priority; len_lat=0.
  - Reset mid-scan aborts the scan silently, with no done pulse.
- FSM states: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - If any req bit is set, pick the first requester at or after rr_ptr, cyclically.
  - Next cycle: grant=onehot(winner), len_lat=len[winner], idx=0, busy=1.
  - If len[winner]!=0, go to RUN with idx_valid=1.
  - If len[winner]==0, go to DONE with idx_valid=0.
  - Latency from req to first idx_valid: 1 cycle.
- RUN:
  - Transfer occurs only when idx_valid&&idx_ready.
  - On a transfer with idx!=len_lat-1: idx<=idx+1, stay in RUN.
  - On a transfer with idx==len_lat-1: go to DONE, idx_valid<=0, and idx holds its last value.
  - Without a transfer, idx and idx_valid hold. A consumer stall of any length is legal.
- DONE (exactly 1 cycle):
  - done=grant (one-hot pulse) and grant stays asserted.
  - Next cycle: state=IDLE, grant=0, done=0, busy=0, idx<=0.
  - rr_ptr<=winner+1, modulo NUM_REQ.
- Re-arbitration: IDLE lasts at least 1 cycle between scans. A req still high after done is re-eligible but has the lowest priority.
- req/len changes during RUN/DONE are ignored. len is sampled only at arbitration, and dropping req does not abort a scan.
- Width rules:
  - len max = 2^CNT_W-1, so the largest index is 2^CNT_W-2.
  - idx never wraps.
  - The comparison uses len_lat-1, computed in CNT_W bits, valid only because len_lat!=0 in RUN.
- Simultaneous events:
  - Multiple req bits in the same cycle are resolved by rr_ptr only.
  - A new req arriving in the DONE cycle is seen in the following IDLE cycle.
- Throughput: one index per cycle while idx_ready=1. Per-scan overhead is 2 cycles (DONE + IDLE).

Decomposition:
- Package neat_sched_pkg:
  - State enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Default CNT_W and NUM_REQ constants.
- Sub-module rr_arbiter (NUM_REQ param):
  - Combinational.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot winner, winner index, any_req.
  - count_sched owns the rr_ptr register.

Test Plan:
- Single requester: req=4'b0001, len0=5, idx_ready=1 -> grant=0001 one cycle after req; idx 0,1,2,3,4 on consecutive cycles with idx_valid=1; done=0001 for 1 cycle; grant=0 next cycle.
- Backpressure: len0=3, idx_ready toggles 1,0,0,1,1 -> idx sequence 0,1,1,1,2; idx holds during stalls; done only after idx=2 is accepted.
- Round-robin fairness: req=4'b1111 held, all len=2 -> grants in order 0001, 0010, 0100, 1000, 0001; each receives exactly 2 indices.
- Zero length: req=4'b0100, len2=0 -> grant=0100 with done=0100 in the same cycle; idx_valid never asserts.
- Async reset mid-scan: rst=0 while idx=3 of len=8 -> grant, idx, idx_valid, busy, done go to 0 immediately, without waiting for clk. After rst=1 with req=4'b0010, requester 1 wins.
- Max length: CNT_W=8, len=255 -> idx runs 0..254 with no wrap; done fires after the transfer of 254.
